// File: rtl/seven_segment_scan_decoder_pkg.sv
// rtl/seven_segment_scan_decoder_pkg.sv - shared 7-segment pattern table, seg[0:6] = a..g
package seven_segment_scan_decoder_pkg;

    localparam logic [0:6] SEG_0 = 7'b1111110;
    localparam logic [0:6] SEG_1 = 7'b0110000;
    localparam logic [0:6] SEG_2 = 7'b1101101;
    localparam logic [0:6] SEG_3 = 7'b1111001;
    localparam logic [0:6] SEG_4 = 7'b0110011;
    localparam logic [0:6] SEG_5 = 7'b1011011;
    localparam logic [0:6] SEG_6 = 7'b1011111;
    localparam logic [0:6] SEG_7 = 7'b1110000;
    localparam logic [0:6] SEG_8 = 7'b1111111;
    localparam logic [0:6] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seven_segment_scan_decoder_seg7_to_bcd.sv
// rtl/seven_segment_scan_decoder_seg7_to_bcd.sv - combinational segment pattern to BCD decoder
module seg7_to_bcd
    import seven_segment_scan_decoder_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] bcd,
    output logic       invalid
);

    always_comb begin
        bcd     = BCD_INVALID;
        invalid = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - scanned display bus to multi-digit BCD frame recovery
module seven_segment_scan_decoder
    import seven_segment_scan_decoder_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:6]            seg,
    input  logic [DIGITS-1:0]     dig,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int              CW      = 4;
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

    logic [DIGITS-1:0]   prev_dig;
    logic [0:6]          prev_seg;
    logic                prev_ok;
    logic [CW-1:0]       cnt;
    logic                captured;
    logic [DIGITS-1:0]   cap_mask;
    logic [4*DIGITS-1:0] buf_bcd;
    logic [DIGITS-1:0]   buf_err;

    logic [3:0]          dec_bcd;
    logic                dec_inv;
    logic                onehot;
    logic                same;
    logic                capture;
    logic                frame_done;
    logic [DIGITS-1:0]   mask_n;
    logic [4*DIGITS-1:0] buf_bcd_n;
    logic [DIGITS-1:0]   buf_err_n;

    seg7_to_bcd u_dec (
        .seg     (seg),
        .bcd     (dec_bcd),
        .invalid (dec_inv)
    );

    assign onehot     = (dig != '0) && ((dig & (dig - DIGITS'(1))) == '0);
    assign same       = prev_ok && (prev_dig == dig) && (prev_seg == seg);
    assign capture    = onehot && same && (cnt == CNT_MAX - CW'(1)) && !captured;
    assign mask_n     = cap_mask | dig;
    assign frame_done = capture && (&mask_n);

    // Buffer image including the digit being captured this cycle, so a
    // completing frame can be forwarded to the output on the same edge.
    always_comb begin
        buf_bcd_n = buf_bcd;
        buf_err_n = buf_err;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig[i]) begin
                buf_bcd_n[4*i +: 4] = dec_bcd;
                buf_err_n[i]        = dec_inv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dig  <= '0;
            prev_seg  <= '0;
            prev_ok   <= 1'b0;
            cnt       <= '0;
            captured  <= 1'b0;
            cap_mask  <= '0;
            buf_bcd   <= '0;
            buf_err   <= '0;
            bcd_out   <= '0;
            err_mask  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prev_dig <= dig;
            prev_seg <= seg;
            prev_ok  <= onehot;

            if (!onehot) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else if (same) begin
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            end else begin
                cnt      <= CW'(1);
                captured <= 1'b0;
            end

            if (capture) begin
                captured <= 1'b1;
                buf_bcd  <= buf_bcd_n;
                buf_err  <= buf_err_n;
                cap_mask <= frame_done ? '0 : mask_n;
            end

            overrun <= 1'b0;
            if (frame_done) begin
                if (!out_valid || out_ready) begin
                    bcd_out   <= buf_bcd_n;
                    err_mask  <= buf_err_n;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - directed vector bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:6]  seg;
    logic [3:0]  dig;
    logic [15:0] bcd_out;
    logic [3:0]  err_mask;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  dig;
        logic [6:0]  seg;
        logic        rdy;
        logic        ev;
        logic [15:0] eb;
        logic [3:0]  ee;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    localparam logic [6:0] BLANK = 7'b0000000;

    logic        exp_valid = 1'b0;
    logic [15:0] exp_bcd   = 16'h0;
    logic [3:0]  exp_err   = 4'h0;

    seven_segment_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dig       (dig),
        .bcd_out   (bcd_out),
        .err_mask  (err_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic [3:0] d, input logic [6:0] s, input logic r, input logic eo);
        vec_t v;
        v.rst = rs; v.dig = d; v.seg = s; v.rdy = r;
        v.ev = exp_valid; v.eb = exp_bcd; v.ee = exp_err; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input logic r, input int n);
        for (int k = 0; k < n; k++) step(1'b0, d, s, r, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; dig = v.dig; seg = v.seg; out_ready = v.rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first;
        rst = 1'b1; dig = '0; seg = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_valid",   -1, 32'(out_valid), 32'd0);
        chk("reset_bcd",     -1, 32'(bcd_out),   32'd0);
        chk("reset_err",     -1, 32'(err_mask),  32'd0);
        chk("reset_overrun", -1, 32'(overrun),   32'd0);

        // 1: basic scan 1,2,3,4
        hold(4'b0001, pat[1], 1'b1, 3);
        hold(4'b0010, pat[2], 1'b1, 3);
        hold(4'b0100, pat[3], 1'b1, 3);
        hold(4'b1000, pat[4], 1'b1, 2);
        exp_valid = 1'b1; exp_bcd = 16'h4321; exp_err = 4'h0;
        step(1'b0, 4'b1000, pat[4], 1'b1, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        // 2: two-cycle hold must not capture
        hold(4'b0100, pat[5], 1'b1, 2);
        hold(4'b1000, pat[7], 1'b1, 3);
        hold(4'b0001, pat[0], 1'b1, 3);
        hold(4'b0010, pat[1], 1'b1, 3);
        hold(4'b0100, pat[5], 1'b1, 2);
        exp_valid = 1'b1; exp_bcd = 16'h7510;
        step(1'b0, 4'b0100, pat[5], 1'b1, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        // 3: blank digit is an error
        hold(4'b0001, pat[9], 1'b1, 3);
        hold(4'b0010, BLANK,  1'b1, 3);
        hold(4'b0100, pat[9], 1'b1, 3);
        hold(4'b1000, pat[9], 1'b1, 2);
        exp_valid = 1'b1; exp_bcd = 16'h99F9; exp_err = 4'b0010;
        step(1'b0, 4'b1000, pat[9], 1'b1, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        // 4: backpressure and overrun
        hold(4'b0001, pat[4], 1'b0, 3);
        hold(4'b0010, pat[3], 1'b0, 3);
        hold(4'b0100, pat[2], 1'b0, 3);
        hold(4'b1000, pat[1], 1'b0, 2);
        exp_valid = 1'b1; exp_bcd = 16'h1234; exp_err = 4'h0;
        step(1'b0, 4'b1000, pat[1], 1'b0, 1'b0);
        hold(4'b0001, pat[8], 1'b0, 3);
        hold(4'b0010, pat[7], 1'b0, 3);
        hold(4'b0100, pat[6], 1'b0, 3);
        hold(4'b1000, pat[5], 1'b0, 2);
        step(1'b0, 4'b1000, pat[5], 1'b0, 1'b1);
        step(1'b0, 4'b0000, BLANK, 1'b0, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        // 5: non-one-hot select never captures
        hold(4'b0010, pat[6], 1'b1, 3);
        hold(4'b0100, pat[7], 1'b1, 3);
        hold(4'b1000, pat[8], 1'b1, 3);
        hold(4'b0011, pat[9], 1'b1, 5);
        hold(4'b0001, pat[9], 1'b1, 2);
        exp_valid = 1'b1; exp_bcd = 16'h8769;
        step(1'b0, 4'b0001, pat[9], 1'b1, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        // 6: reset discards partial frame, then recapture overwrites
        hold(4'b0001, pat[1], 1'b1, 3);
        hold(4'b0010, pat[2], 1'b1, 3);
        hold(4'b0100, pat[3], 1'b1, 3);
        exp_bcd = 16'h0;
        step(1'b1, 4'b0000, BLANK, 1'b1, 1'b0);
        hold(4'b1000, pat[4], 1'b1, 5);
        hold(4'b0001, pat[5], 1'b1, 3);
        hold(4'b0001, pat[9], 1'b1, 3);
        hold(4'b0010, pat[6], 1'b1, 3);
        hold(4'b0100, pat[7], 1'b1, 2);
        exp_valid = 1'b1; exp_bcd = 16'h4769;
        step(1'b0, 4'b0100, pat[7], 1'b1, 1'b0);
        exp_valid = 1'b0;
        step(1'b0, 4'b0000, BLANK, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            chk("valid",   i, 32'(out_valid), 32'(vecs[i].ev));
            chk("bcd",     i, 32'(bcd_out),   32'(vecs[i].eb));
            chk("err",     i, 32'(err_mask),  32'(vecs[i].ee));
            chk("overrun", i, 32'(overrun),   32'(vecs[i].eo));
        end

        // Latency of a full frame of 8s, counted in clock edges, with bounded scan
        first = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                rst = 1'b0; dig = 4'(1 << d); seg = pat[8]; out_ready = 1'b0;
                @(posedge clk);
                #1;
                if (out_valid && first == 0) first = d * 3 + c + 1;
            end
        end
        chk("latency_edges", 0, 32'(first), 32'd12);
        chk("latency_bcd",   0, 32'(bcd_out), 32'h8888);
        @(negedge clk);
        dig = '0; seg = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("latency_accept", 0, 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
